// File: rtl/mem_bist_if.sv
// mem_bist_if: host-side request/response bus between the BIST initiator and the memory controller
interface mem_bist_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  mem_rd_o;
  logic                  mem_wr_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdt_o;
  logic                  mem_busy_i;
  logic [DATA_WIDTH-1:0] mem_rdt_i;
  logic                  mem_wok_i;
  modport master (
    output mem_rd_o, mem_wr_o, mem_addr_o, mem_wdt_o,
    input  mem_busy_i, mem_rdt_i, mem_wok_i
  );
  modport slave (
    input  mem_rd_o, mem_wr_o, mem_addr_o, mem_wdt_o,
    output mem_busy_i, mem_rdt_i, mem_wok_i
  );
endinterface

// File: rtl/mem_bist.sv
// mem_bist: writes a x3 pattern to every word, reads it back, reports errors and timeouts
module mem_bist #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int N_OF_WORDS = 256,
  parameter int SEED       = 16'h1010,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [15:0]           err_cnt_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  mem_bist_if.master            mem
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [DATA_WIDTH-1:0] SEED_W = DATA_WIDTH'(SEED);
  state_t state, nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] pat;
  logic [CW-1:0] cnt;
  logic wok_seen, tmo, step, wr_err, rd_err, to, last, expired, launch;
  assign last    = addr == ADDR_WIDTH'(N_OF_WORDS - 1);
  assign expired = cnt == CW'(TIMEOUT - 1);
  assign launch  = (state == IDLE || state == DONE) && start_i;
  always_comb begin
    nxt    = state;
    step   = 1'b0;
    wr_err = 1'b0;
    rd_err = 1'b0;
    to     = 1'b0;
    case (state)
      IDLE, DONE: nxt = start_i ? WR_REQ : state;
      WR_REQ: begin
        to  = !mem.mem_busy_i && expired;
        nxt = mem.mem_busy_i ? WR_WAIT : to ? DONE : state;
      end
      WR_WAIT: begin
        step   = !mem.mem_busy_i;
        wr_err = step && !(wok_seen || mem.mem_wok_i);
        to     = mem.mem_busy_i && expired;
        nxt    = step ? (last ? RD_REQ : WR_REQ) : to ? DONE : state;
      end
      RD_REQ: begin
        to  = !mem.mem_busy_i && expired;
        nxt = mem.mem_busy_i ? RD_WAIT : to ? DONE : state;
      end
      RD_WAIT: begin
        step   = !mem.mem_busy_i;
        rd_err = step && (mem.mem_rdt_i != pat);
        to     = mem.mem_busy_i && expired;
        nxt    = step ? (last ? DONE : RD_REQ) : to ? DONE : state;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else       state <= nxt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr        <= '0;
      pat         <= '0;
      cnt         <= '0;
      wok_seen    <= 1'b0;
      tmo         <= 1'b0;
      err_cnt_o   <= '0;
      fail_addr_o <= '0;
      fail_data_o <= '0;
    end else begin
      cnt <= (nxt != state) ? '0 : cnt + CW'(1);
      if (launch) begin
        addr        <= '0;
        pat         <= SEED_W;
        tmo         <= 1'b0;
        err_cnt_o   <= '0;
        fail_addr_o <= '0;
        fail_data_o <= '0;
      end
      if (step) begin
        addr <= last ? '0 : addr + ADDR_WIDTH'(1);
        pat  <= last ? SEED_W : pat + (pat << 1);
      end
      if (state == WR_REQ) wok_seen <= mem.mem_wok_i;
      if (state == WR_WAIT) wok_seen <= wok_seen | mem.mem_wok_i;
      if (wr_err || rd_err) begin
        if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
        if (err_cnt_o == 16'd0) begin
          fail_addr_o <= addr;
          fail_data_o <= rd_err ? mem.mem_rdt_i : pat;
        end
      end
      if (to) begin
        tmo <= 1'b1;
        if (err_cnt_o == 16'd0) fail_addr_o <= addr;
      end
    end
  end
  assign busy_o         = state != IDLE && state != DONE;
  assign done_o         = state == DONE;
  assign pass_o         = done_o && err_cnt_o == 16'd0 && !tmo;
  assign timeout_o      = tmo;
  assign mem.mem_wr_o   = state == WR_REQ;
  assign mem.mem_rd_o   = state == RD_REQ;
  assign mem.mem_addr_o = addr;
  assign mem.mem_wdt_o  = pat;
endmodule

// File: doc/mem_bist.md
Name: mem_bist

Overview:
- Self-contained initiator for the host side of the memory controller: the host side is the rd/wr/addr/wdt request port with busy/rdt/wok responses.
- On start, it writes a deterministic pattern to every word, then reads every word back and checks it against the same pattern.
- It reports pass/fail, an error count and the first failing location.
- It replaces the hand-driven stimulus in front of the controller, both in integration benches and as an on-chip memory self-test.

Parameters:
- DATA_WIDTH, 16: width of mem_wdt_o / mem_rdt_i.
- ADDR_WIDTH, 10: width of mem_addr_o.
- N_OF_WORDS, 256: words tested, addresses 0..N_OF_WORDS-1. Requires N_OF_WORDS <= 2**ADDR_WIDTH.
- SEED, 16'h1010: first pattern word, truncated/zero-extended to DATA_WIDTH.
- TIMEOUT, 64: maximum cycles spent in any single request or wait state.

Ports:
- clk_i  in  1  system clock, same clock as the controller.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  1-cycle start pulse; ignored while busy_o=1.
- busy_o  out  1  test in progress.
- done_o  out  1  level; high from test end until the next accepted start or reset.
- pass_o  out  1  valid when done_o=1; high iff err_cnt_o=0 and timeout_o=0.
- timeout_o  out  1  test aborted on timeout.
- err_cnt_o  out  16  saturating count of mismatches plus missing write acks.
- fail_addr_o  out  ADDR_WIDTH  address of the first error.
- fail_data_o  out  DATA_WIDTH  read data (read error) or expected data (write-ack error) at the first error.
- mem_rd_o  out  1  read request strobe to the controller.
- mem_wr_o  out  1  write request strobe to the controller.
- mem_addr_o  out  ADDR_WIDTH  request address.
- mem_wdt_o  out  DATA_WIDTH  write data.
- mem_busy_i  in  1  controller busy.
- mem_rdt_i  in  DATA_WIDTH  controller read data.
- mem_wok_i  in  1  controller write-complete pulse.

Behaviour:
- **Reset.** rst_i=1 at a clock edge sets the FSM to IDLE. All outputs go to 0 on that edge, including in the middle of a transaction; no request is completed or retried.
- **Pattern.** P(0)=SEED; P(k+1)=(P(k)*3) mod 2**DATA_WIDTH, implemented as P+(P<<1). The pattern register reloads SEED at the start of each phase. Example: 16'h1010, 16'h3030, 16'h9090, 16'hB1B0.
- **FSM states.** IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
- **IDLE/DONE + start_i.**
  - Clear err_cnt_o, fail_addr_o, fail_data_o and timeout_o; drop done_o and pass_o.
  - Set addr=0 and pattern=SEED.
  - Go to WR_REQ; busy_o=1 from the next cycle.
- **WR_REQ.**
  - Drive mem_wr_o=1, mem_addr_o=addr, mem_wdt_o=P.
  - When mem_busy_i=1, go to WR_WAIT and drop mem_wr_o on that transition.
  - Clear the wok_seen flag, then set it if mem_wok_i=1 in this cycle.
- **WR_WAIT.**
  - Hold mem_addr_o and mem_wdt_o stable; set wok_seen whenever mem_wok_i=1.
  - When mem_busy_i=0, the write is complete. If wok_seen=0 and mem_wok_i=0, record a write-ack error.
  - If addr=N_OF_WORDS-1: set addr=0, P=SEED, go to RD_REQ. Otherwise: addr+1, advance P, go to WR_REQ.
- **RD_REQ.** Drive mem_rd_o=1; when mem_busy_i=1, go to RD_WAIT and drop mem_rd_o.
- **RD_WAIT.**
  - When mem_busy_i=0, sample mem_rdt_i in that same cycle. If it differs from P, record a read error.
  - If addr=N_OF_WORDS-1: go to DONE. Otherwise: addr+1, advance P, go to RD_REQ.
- **Error recording.**
  - err_cnt_o increments by 1 and saturates at 16'hFFFF.
  - fail_addr_o and fail_data_o are captured only when err_cnt_o was 0 before the increment.
- **Timeout.**
  - A cycle counter resets on every state change and counts while in WR_REQ, WR_WAIT, RD_REQ or RD_WAIT.
  - When it reaches TIMEOUT-1 without the awaited condition: timeout_o=1, strobes low, go to DONE.
  - On timeout, fail_addr_o=current addr if no earlier error was captured; err_cnt_o is unchanged.
- **DONE.** done_o=1, busy_o=0, pass_o=(err_cnt_o==0 && !timeout_o); status holds until start_i or reset.
- **Strobe rules.** At most one of mem_rd_o and mem_wr_o is high in any cycle. Each strobe is high only in its REQ state.
- **Simultaneous events.**
  - start_i together with rst_i: reset wins.
  - start_i while busy_o=1: ignored.
  - If busy deasserts in the same cycle the controller accepts, that is handled as a stay in WR_WAIT/RD_WAIT for at least 1 cycle.
- **Latency.** Per word: 1 cycle of REQ minimum plus the controller's busy duration.

Test Plan:
- **Reset values.** Assert rst_i for 2 cycles, then release with start_i=0 → every output 0, FSM idle, no strobes for 10 cycles.
- **Clean pass.** Run against a controller model with 3-cycle busy and a correct memory → writes to addr 0,1,2,3 carry 16'h1010, 16'h3030, 16'h9090, 16'hB1B0; 256 writes then 256 reads; done_o=1, pass_o=1, err_cnt_o=0.
- **Read mismatch.** Model returns 16'h9091 for addr 2 → err_cnt_o=1, fail_addr_o=2, fail_data_o=16'h9091, pass_o=0.
- **Missing write ack.** Suppress mem_wok_i for addr 5, plus read errors at addr 7 and 9 → err_cnt_o=3, fail_addr_o=5, fail_data_o=P(5), pass_o=0.
- **Timeout.** Hold mem_busy_i=0 permanently → mem_wr_o high for exactly TIMEOUT cycles at addr 0, then timeout_o=1, done_o=1, pass_o=0, fail_addr_o=0.
- **Reset mid-test.** Assert rst_i during RD_WAIT at addr 100 → all outputs 0 on the next edge; a new start_i then completes a full clean pass.
